// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control sequencer.
//   state_e       sequencer states (StTrap is reachable only with ILLEGAL_TRAP_EN)
//   OP_*          major opcodes recognised in DECODE
//   *_e           encodings of the datapath mux selects and ALU operation
//   imm_src_of    immediate format decode from opcode
//   is_known_op   opcode has a defined execution path
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StTrap
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    AluAPc    = 2'd0,
    AluAOldPc = 2'd1,
    AluARs1   = 2'd2
  } alu_src_a_e;

  typedef enum logic [1:0] {
    AluBRs2  = 2'd0,
    AluBImm  = 2'd1,
    AluBFour = 2'd2
  } alu_src_b_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'd0,
    AluOpSub   = 2'd1,
    AluOpFunct = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    ResAluOut    = 2'd0,
    ResMemData   = 2'd1,
    ResAluResult = 2'd2
  } result_src_e;

  typedef enum logic [1:0] {
    ImmI = 2'd0,
    ImmS = 2'd1,
    ImmB = 2'd2,
    ImmJ = 2'd3
  } imm_src_e;

  function automatic imm_src_e imm_src_of(input logic [6:0] op);
    imm_src_e imm;
    imm = ImmI;
    case (op)
      OP_STORE:  imm = ImmS;
      OP_BRANCH: imm = ImmB;
      OP_JAL:    imm = ImmJ;
      default:   imm = ImmI;
    endcase
    return imm;
  endfunction

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) || (op == OP_ITYPE) ||
           (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Memory wait watchdog. Counts consecutive cycles an outstanding request goes unacknowledged
// and flags expiry on the MEM_TIMEOUT-th such cycle.
//   clk      in  clock
//   reset    in  synchronous, active-low
//   waiting  in  request outstanding and not acknowledged this cycle
//   expired  out combinational; high in the cycle the wait reaches MEM_TIMEOUT
// The count clears whenever waiting drops (acknowledge or leaving a memory state) and on expiry.
module mc_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic expired
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q holds completed wait cycles, so the current cycle is number cnt_q + 1.
  always_comb begin
    expired = waiting && (cnt_q == CntW'(MEM_TIMEOUT - 1));
    cnt_d   = '0;
    if (waiting && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Main sequencer for the multicycle RV32I core: fetch, decode, execute, memory and writeback.
// Build option: ILLEGAL_TRAP_EN -- unknown opcodes and memory timeouts enter an absorbing TRAP
// state and a trap output port is added; otherwise unknown opcodes retire as NOPs.
//   clk, reset       clock; synchronous active-low reset
//   opcode           instr[6:0] from IR
//   zero             ALU zero flag, used in BRANCH
//   mem_ready        memory handshake acknowledge
//   mem_req/mem_write/adr_src          memory request, store strobe, address select
//   ir_write/pc_en                     IR/old-PC load, PC enable
//   alu_src_a/alu_src_b/alu_op         ALU operand selects and operation
//   result_src/imm_src                 result mux and immediate format
//   reg_write/instr_done               regfile strobe, retire pulse
//   trap (ILLEGAL_TRAP_EN only)        in TRAP state
//   bus_err                            sticky memory-timeout flag
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_done,
`ifdef ILLEGAL_TRAP_EN
  output logic       trap,
`endif
  output logic       bus_err
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_e AbortSt = StTrap;
  localparam logic   NopRetire = 1'b0;
`else
  localparam state_e AbortSt = StFetch;
  localparam logic   NopRetire = 1'b1;
`endif

  state_e state_q, state_d;
  logic   bus_err_q;
  logic   mem_state;
  logic   waiting;
  logic   expired;

  assign mem_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  assign waiting   = mem_state && !mem_ready;

  mc_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .waiting(waiting),
    .expired(expired)
  );

  // Next state. expired can only be high when mem_ready is low, so mem_ready wins by construction.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (expired) begin
          state_d = AbortSt;
        end
      end
      StDecode: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = StMemAdr;
          OP_RTYPE:          state_d = StExecR;
          OP_ITYPE:          state_d = StExecI;
          OP_BRANCH:         state_d = StBranch;
          OP_JAL:            state_d = StJal;
          default:           state_d = AbortSt;
        endcase
      end
      StMemAdr:  state_d = (opcode == OP_LOAD) ? StMemRead : StMemWrite;
      StMemRead: begin
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (expired) begin
          state_d = AbortSt;
        end
      end
      StMemWb:   state_d = StFetch;
      StMemWrite: begin
        if (mem_ready) begin
          state_d = StFetch;
        end else if (expired) begin
          state_d = AbortSt;
        end
      end
      StExecR:   state_d = StAluWb;
      StExecI:   state_d = StAluWb;
      StAluWb:   state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJal:     state_d = StAluWb;
      StTrap:    state_d = AbortSt;
      default:   state_d = StFetch;
    endcase
  end

  // Moore decode of state; ir_write, pc_en and store retire additionally gated by mem_ready.
  always_comb begin
    mem_req    = mem_state;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    alu_src_a  = AluAPc;
    alu_src_b  = AluBRs2;
    alu_op     = AluOpAdd;
    result_src = ResAluOut;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    imm_src    = imm_src_of(opcode);
    unique case (state_q)
      StFetch: begin
        adr_src    = 1'b0;
        alu_src_a  = AluAPc;
        alu_src_b  = AluBFour;
        alu_op     = AluOpAdd;
        result_src = ResAluResult;
        ir_write   = mem_ready;
        pc_en      = mem_ready;
      end
      StDecode: begin
        alu_src_a  = AluAOldPc;
        alu_src_b  = AluBImm;
        instr_done = NopRetire && !is_known_op(opcode);
      end
      StMemAdr: begin
        alu_src_a = AluARs1;
        alu_src_b = AluBImm;
        alu_op    = AluOpAdd;
      end
      StMemRead: begin
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src = ResMemData;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StMemWrite: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      StExecR: begin
        alu_src_a = AluARs1;
        alu_src_b = AluBRs2;
        alu_op    = AluOpFunct;
      end
      StExecI: begin
        alu_src_a = AluARs1;
        alu_src_b = AluBImm;
        alu_op    = AluOpFunct;
      end
      StAluWb: begin
        result_src = ResAluOut;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a  = AluARs1;
        alu_src_b  = AluBRs2;
        alu_op     = AluOpSub;
        result_src = ResAluOut;
        pc_en      = zero;
        instr_done = 1'b1;
      end
      StJal: begin
        alu_src_a  = AluAOldPc;
        alu_src_b  = AluBFour;
        alu_op     = AluOpAdd;
        result_src = ResAluOut;
        pc_en      = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign trap = (state_q == StTrap);
`endif

  assign bus_err = bus_err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (expired) begin
        bus_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_en;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
  logic       reg_write, instr_done, bus_err;
  logic       trap_w;

  int checks = 0;
  int errors = 0;
  bit err_exp = 1'b0;

  typedef struct {
    string       tag;
    logic [18:0] val;
    logic [18:0] care;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mc_control_fsm #(
    .MEM_TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_write (mem_write),
    .adr_src   (adr_src),
    .ir_write  (ir_write),
    .pc_en     (pc_en),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .result_src(result_src),
    .imm_src   (imm_src),
    .reg_write (reg_write),
    .instr_done(instr_done),
`ifdef ILLEGAL_TRAP_EN
    .trap      (trap_w),
`endif
    .bus_err   (bus_err)
  );

`ifndef ILLEGAL_TRAP_EN
  assign trap_w = 1'b0;
`endif

  // Bit layout: [18]trap [17]mem_req [16]mem_write [15]adr_src [14]ir_write [13]pc_en
  // [12:11]alu_src_a [10:9]alu_src_b [8:7]alu_op [6:5]result_src [4:3]imm_src
  // [2]reg_write [1]instr_done [0]bus_err. Negative int field = don't care.
  function automatic exp_t mk(string tag, bit mreq, bit mwr, int adr, bit irw, bit pce, int a,
                              int b, int op, int res, int imm, bit rw, bit done);
    exp_t e;
    e.tag  = tag;
    e.val  = '0;
    e.care = '1;
    e.val[17] = mreq;
    e.val[16] = mwr;
    if (adr < 0) e.care[15] = 1'b0; else e.val[15] = adr[0];
    e.val[14] = irw;
    e.val[13] = pce;
    if (a < 0) e.care[12:11] = 2'b00; else e.val[12:11] = a[1:0];
    if (b < 0) e.care[10:9] = 2'b00; else e.val[10:9] = b[1:0];
    if (op < 0) e.care[8:7] = 2'b00; else e.val[8:7] = op[1:0];
    if (res < 0) e.care[6:5] = 2'b00; else e.val[6:5] = res[1:0];
    if (imm < 0) e.care[4:3] = 2'b00; else e.val[4:3] = imm[1:0];
    e.val[2] = rw;
    e.val[1] = done;
    e.val[0] = err_exp;
    return e;
  endfunction

  function automatic exp_t e_fetch(string t, bit rdy);
    return mk(t, 1, 0, 0, rdy, rdy, 0, 2, 0, 2, -1, 0, 0);
  endfunction
  function automatic exp_t e_decode(string t, int imm, bit done);
    return mk(t, 0, 0, -1, 0, 0, 1, 1, -1, -1, imm, 0, done);
  endfunction
  function automatic exp_t e_memadr(string t);
    return mk(t, 0, 0, -1, 0, 0, 2, 1, 0, -1, -1, 0, 0);
  endfunction
  function automatic exp_t e_memread(string t);
    return mk(t, 1, 0, 1, 0, 0, -1, -1, -1, -1, -1, 0, 0);
  endfunction
  function automatic exp_t e_memwb(string t);
    return mk(t, 0, 0, -1, 0, 0, -1, -1, -1, 1, -1, 1, 1);
  endfunction
  function automatic exp_t e_memwrite(string t, bit rdy);
    return mk(t, 1, 1, 1, 0, 0, -1, -1, -1, -1, -1, 0, rdy);
  endfunction
  function automatic exp_t e_exec(string t, bit imm_b);
    return mk(t, 0, 0, -1, 0, 0, 2, imm_b ? 1 : 0, 2, -1, -1, 0, 0);
  endfunction
  function automatic exp_t e_aluwb(string t);
    return mk(t, 0, 0, -1, 0, 0, -1, -1, -1, 0, -1, 1, 1);
  endfunction
  function automatic exp_t e_branch(string t, bit z);
    return mk(t, 0, 0, -1, 0, z, 2, 0, 1, 0, -1, 0, 1);
  endfunction
  function automatic exp_t e_jal(string t);
    return mk(t, 0, 0, -1, 0, 1, 1, 2, 0, 0, -1, 0, 0);
  endfunction
  function automatic exp_t e_trap(string t);
    exp_t e;
    e = mk(t, 0, 0, -1, 0, 0, -1, -1, -1, -1, -1, 0, 0);
    e.val[18] = 1'b1;
    return e;
  endfunction

  task automatic check_out();
    exp_t        e;
    logic [18:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed none expected entry");
      return;
    end
    e   = sb.pop_front();
    obs = {trap_w, mem_req, mem_write, adr_src, ir_write, pc_en, alu_src_a, alu_src_b, alu_op,
           result_src, imm_src, reg_write, instr_done, bus_err};
    assert ((obs & e.care) === (e.val & e.care)) else begin
      errors++;
      $error("FAIL %s observed %05h expected %05h (care %05h)", e.tag, obs & e.care,
             e.val & e.care, e.care);
    end
  endtask

  // Drive one cycle's inputs, queue its expectation, compare mid-cycle, advance past the edge.
  task automatic step(input logic [6:0] opc, input logic z, input logic rdy, input exp_t e);
    opcode    = opc;
    zero      = z;
    mem_ready = rdy;
    sb.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    err_exp = 1'b0;
    step(7'h00, 0, 0, e_fetch("reset_fetch", 0));
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] OpLoad = 7'b0000011, OpStore = 7'b0100011, OpR = 7'b0110011;
  localparam logic [6:0] OpI = 7'b0010011, OpBr = 7'b1100011, OpJal = 7'b1101111;
  localparam logic [6:0] OpBad = 7'b1111111;

  initial begin
    reset = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Immediate fetch, then R-type.
    step(OpR, 0, 1, e_fetch("t1_fetch", 1));
    step(OpR, 0, 0, e_decode("t1_decode", -1, 0));
    step(OpR, 0, 0, e_exec("t1_execr", 0));
    step(OpR, 0, 0, e_aluwb("t1_aluwb"));

    // Fetch waits three cycles, then I-type.
    for (int i = 0; i < 3; i++) step(OpI, 0, 0, e_fetch($sformatf("t2_wait%0d", i), 0));
    step(OpI, 0, 1, e_fetch("t2_fetch", 1));
    step(OpI, 0, 0, e_decode("t2_decode", 0, 0));
    step(OpI, 0, 0, e_exec("t2_execi", 1));
    step(OpI, 0, 0, e_aluwb("t2_aluwb"));

    // Load with ready held high (ignored in non-memory states).
    step(OpLoad, 0, 1, e_fetch("t3_fetch", 1));
    step(OpLoad, 0, 1, e_decode("t3_decode", 0, 0));
    step(OpLoad, 0, 1, e_memadr("t3_memadr"));
    step(OpLoad, 0, 1, e_memread("t3_memread"));
    step(OpLoad, 0, 1, e_memwb("t3_memwb"));

    // Branch taken and not taken.
    step(OpBr, 1, 1, e_fetch("t4_fetch_a", 1));
    step(OpBr, 1, 0, e_decode("t4_decode_a", 2, 0));
    step(OpBr, 1, 0, e_branch("t4_taken", 1));
    step(OpBr, 0, 1, e_fetch("t4_fetch_b", 1));
    step(OpBr, 0, 0, e_decode("t4_decode_b", 2, 0));
    step(OpBr, 0, 0, e_branch("t4_not_taken", 0));

    // JAL.
    step(OpJal, 0, 1, e_fetch("jal_fetch", 1));
    step(OpJal, 0, 0, e_decode("jal_decode", 3, 0));
    step(OpJal, 0, 0, e_jal("jal_exec"));
    step(OpJal, 0, 0, e_aluwb("jal_aluwb"));

    // Store acknowledged on the 16th cycle: one short of the timeout.
    step(OpStore, 0, 1, e_fetch("st15_fetch", 1));
    step(OpStore, 0, 0, e_decode("st15_decode", 1, 0));
    step(OpStore, 0, 0, e_memadr("st15_memadr"));
    for (int i = 0; i < 15; i++) step(OpStore, 0, 0, e_memwrite($sformatf("st15_wait%0d", i), 0));
    step(OpStore, 0, 1, e_memwrite("st15_ack", 1));
    step(OpStore, 0, 1, e_fetch("st15_back", 1));

    // Unknown opcode.
    step(OpBad, 0, 0, e_decode("bad_decode", -1,
`ifdef ILLEGAL_TRAP_EN
                                1'b0));
    for (int i = 0; i < 3; i++) step(OpBad, 0, 1, e_trap($sformatf("bad_trap%0d", i)));
`else
                                1'b1));
    step(OpR, 0, 0, e_fetch("bad_nop_fetch", 0));
`endif
    do_reset();

    // Store never acknowledged: timeout on the 16th wait cycle.
    step(OpStore, 0, 1, e_fetch("to_fetch", 1));
    step(OpStore, 0, 0, e_decode("to_decode", 1, 0));
    step(OpStore, 0, 0, e_memadr("to_memadr"));
    for (int i = 0; i < 16; i++) step(OpStore, 0, 0, e_memwrite($sformatf("to_wait%0d", i), 0));
    err_exp = 1'b1;
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) step(OpR, 0, 1, e_trap($sformatf("to_trap%0d", i)));
`else
    step(OpR, 0, 0, e_fetch("to_abort_fetch", 0));
    step(OpR, 0, 1, e_fetch("to_sticky_fetch", 1));
    step(OpR, 0, 0, e_decode("to_sticky_decode", -1, 0));
    step(OpR, 0, 0, e_exec("to_sticky_execr", 0));
    step(OpR, 0, 0, e_aluwb("to_sticky_aluwb"));
`endif
    do_reset();
    step(OpR, 0, 1, e_fetch("post_reset_fetch", 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
